// File: rtl/hc05_responder.sv
// Serial-side model of an HC-05 module: an 8N1 receiver and transmitter, plus a control FSM.
// In AT mode it answers CR-LF command lines with OK or ERROR; in data mode it connects and echoes bytes.
module hc05_responder #(
    parameter logic [15:0] CONNECT_DELAY = 16'd1000,
    parameter int          LINE_MAX      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] cycles_per_databit,
    input  logic       enable_in,
    input  logic       at_mode,
    input  logic       rx_line,
    output logic       tx_line,
    output logic       state_out,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_error,
    output logic       overrun,
    output logic       tx_busy
);
    localparam int IDX_W = $clog2(LINE_MAX);
    localparam int CNT_W = $clog2(LINE_MAX + 1);
    localparam logic [CNT_W-1:0] LINE_FULL = CNT_W'(LINE_MAX);
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // ------------------------------------------------------------------ RX
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t  rx_state;
    logic       rx_meta, rx_sync, rx_prev;
    logic [9:0] rx_cpd, rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;
    logic       rx_bit_end;

    assign rx_bit_end = (rx_cnt == rx_cpd - 10'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state      <= RX_IDLE;
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            rx_prev       <= 1'b1;
            rx_cpd        <= 10'd0;
            rx_cnt        <= 10'd0;
            rx_bit        <= 3'd0;
            rx_shift      <= 8'h00;
            rx_byte       <= 8'h00;
            rx_byte_valid <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            rx_meta       <= rx_line;
            rx_sync       <= rx_meta;
            rx_prev       <= rx_sync;
            rx_byte_valid <= 1'b0;
            frame_error   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cpd   <= cycles_per_databit;
                        rx_cnt   <= 10'd0;
                    end
                end
                RX_START: begin
                    // Mid-start re-check: a line that is high again was only a glitch.
                    if (rx_cnt == {1'b0, rx_cpd[9:1]} - 10'd1) begin
                        rx_cnt   <= 10'd0;
                        rx_bit   <= 3'd0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 10'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= 10'd0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 10'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= 10'd0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_byte       <= rx_shift;
                            rx_byte_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 10'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------ TX
    logic [9:0] tx_cpd, tx_cnt;
    logic [3:0] tx_bit;
    logic [8:0] tx_shift;
    logic       tx_last, tx_free, tx_load;
    logic [7:0] tx_data;

    // A frame may be loaded in the final stop-bit cycle, so frames run back to back.
    assign tx_last = tx_busy && (tx_cnt == tx_cpd - 10'd1) && (tx_bit == 4'd9);
    assign tx_free = !tx_busy || tx_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_line  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cpd   <= 10'd0;
            tx_cnt   <= 10'd0;
            tx_bit   <= 4'd0;
            tx_shift <= 9'h1FF;
        end else if (tx_load) begin
            tx_line  <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cpd   <= cycles_per_databit;
            tx_cnt   <= 10'd0;
            tx_bit   <= 4'd0;
            tx_shift <= {1'b1, tx_data};
        end else if (tx_busy) begin
            if (tx_cnt == tx_cpd - 10'd1) begin
                tx_cnt <= 10'd0;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                end else begin
                    tx_line  <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                    tx_bit   <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------- control
    typedef enum logic [2:0] {
        CTL_DISABLED, CTL_AT_COLLECT, CTL_AT_RESPOND, CTL_CONNECTING, CTL_CONNECTED
    } ctl_state_t;

    ctl_state_t       ctl_state;
    logic [7:0]       line_buf [LINE_MAX];
    logic [CNT_W-1:0] line_cnt;
    logic             ovf, cr_seen, resp_ok, line_ok;
    logic [2:0]       resp_idx, resp_len;
    logic [15:0]      conn_cnt;
    logic [7:0]       pend_data;
    logic             pend_valid;
    logic             lf_done;

    function automatic logic [7:0] resp_rom(input logic ok, input logic [2:0] idx);
        case ({ok, idx})
            4'b1_000: resp_rom = 8'h4F;
            4'b1_001: resp_rom = 8'h4B;
            4'b1_010: resp_rom = 8'h0D;
            4'b1_011: resp_rom = 8'h0A;
            4'b0_000: resp_rom = 8'h45;
            4'b0_001: resp_rom = 8'h52;
            4'b0_010: resp_rom = 8'h52;
            4'b0_011: resp_rom = 8'h4F;
            4'b0_100: resp_rom = 8'h52;
            4'b0_101: resp_rom = 8'h0D;
            4'b0_110: resp_rom = 8'h0A;
            default:  resp_rom = 8'h00;
        endcase
    endfunction

    assign line_ok  = !ovf && (line_cnt >= CNT_W'(2)) &&
                      (line_buf[0] == 8'h41) && (line_buf[1] == 8'h54);
    assign resp_len = resp_ok ? 3'd4 : 3'd7;
    assign lf_done  = rx_byte_valid && (rx_byte == CHAR_LF) && cr_seen;

    always_comb begin
        tx_load = 1'b0;
        tx_data = 8'h00;
        case (ctl_state)
            CTL_AT_COLLECT: begin
                if (lf_done && tx_free) begin
                    tx_load = 1'b1;
                    tx_data = resp_rom(line_ok, 3'd0);
                end
            end
            CTL_AT_RESPOND: begin
                if (resp_idx != resp_len && tx_free) begin
                    tx_load = 1'b1;
                    tx_data = resp_rom(resp_ok, resp_idx);
                end
            end
            CTL_CONNECTED: begin
                if (tx_free && pend_valid) begin
                    tx_load = 1'b1;
                    tx_data = pend_data;
                end else if (tx_free && rx_byte_valid) begin
                    tx_load = 1'b1;
                    tx_data = rx_byte;
                end
            end
            default: ;
        endcase
        if (!enable_in) tx_load = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctl_state  <= CTL_DISABLED;
            for (int i = 0; i < LINE_MAX; i++) line_buf[i] <= 8'h00;
            line_cnt   <= '0;
            ovf        <= 1'b0;
            cr_seen    <= 1'b0;
            resp_ok    <= 1'b0;
            resp_idx   <= 3'd0;
            conn_cnt   <= 16'd0;
            pend_data  <= 8'h00;
            pend_valid <= 1'b0;
            state_out  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (!enable_in || ctl_state == CTL_DISABLED) begin
                line_cnt   <= '0;
                ovf        <= 1'b0;
                cr_seen    <= 1'b0;
                resp_idx   <= 3'd0;
                conn_cnt   <= 16'd0;
                pend_valid <= 1'b0;
                state_out  <= 1'b0;
                if (!enable_in)   ctl_state <= CTL_DISABLED;
                else if (at_mode) ctl_state <= CTL_AT_COLLECT;
                else              ctl_state <= CTL_CONNECTING;
            end else begin
                case (ctl_state)
                    CTL_AT_COLLECT: begin
                        if (rx_byte_valid) begin
                            if (rx_byte == CHAR_CR) begin
                                cr_seen <= 1'b1;
                            end else begin
                                cr_seen <= 1'b0;
                                if (rx_byte == CHAR_LF) begin
                                    if (cr_seen) begin
                                        ctl_state <= CTL_AT_RESPOND;
                                        resp_ok   <= line_ok;
                                        resp_idx  <= tx_free ? 3'd1 : 3'd0;
                                    end
                                end else if (line_cnt < LINE_FULL) begin
                                    line_buf[line_cnt[IDX_W-1:0]] <= rx_byte;
                                    line_cnt <= line_cnt + CNT_W'(1);
                                end else begin
                                    ovf <= 1'b1;
                                end
                            end
                        end
                    end
                    CTL_AT_RESPOND: begin
                        if (tx_load) begin
                            resp_idx <= resp_idx + 3'd1;
                        end else if (resp_idx == resp_len && tx_last) begin
                            ctl_state <= CTL_AT_COLLECT;
                            line_cnt  <= '0;
                            ovf       <= 1'b0;
                            cr_seen   <= 1'b0;
                        end
                    end
                    CTL_CONNECTING: begin
                        if (conn_cnt == CONNECT_DELAY - 16'd1) begin
                            ctl_state <= CTL_CONNECTED;
                            state_out <= 1'b1;
                        end else begin
                            conn_cnt <= conn_cnt + 16'd1;
                        end
                    end
                    CTL_CONNECTED: begin
                        // When TX frees as a byte arrives, pending goes out and the new byte takes its place.
                        if (rx_byte_valid) begin
                            if (tx_free) begin
                                if (pend_valid) pend_data <= rx_byte;
                            end else if (!pend_valid) begin
                                pend_data  <= rx_byte;
                                pend_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else if (pend_valid && tx_free) begin
                            pend_valid <= 1'b0;
                        end
                    end
                    default: ctl_state <= CTL_DISABLED;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hc05_responder.sv
// Bench for hc05_responder: drives 8N1 frames into rx_line and decodes tx_line,
// comparing received and transmitted bytes against expected queues.
`timescale 1ns/1ps
module tb_hc05_responder;
  localparam logic [15:0] CD = 16'd100;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] cycles_per_databit;
  logic       enable_in, at_mode, rx_line;
  logic       tx_line, state_out, rx_byte_valid, frame_error, overrun, tx_busy;
  logic [7:0] rx_byte;

  int cpd = 26;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_exp_q[$];
  int         frame_starts[$];

  int rx_valid_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, last_valid_cyc = 0;
  bit state_hi_seen = 1'b0;

  assign cycles_per_databit = cpd[9:0];

  hc05_responder #(.CONNECT_DELAY(CD), .LINE_MAX(16)) dut (
    .clock(clock), .reset(reset), .cycles_per_databit(cycles_per_databit),
    .enable_in(enable_in), .at_mode(at_mode), .rx_line(rx_line),
    .tx_line(tx_line), .state_out(state_out), .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid), .frame_error(frame_error),
    .overrun(overrun), .tx_busy(tx_busy)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    repeat (80000) @(posedge clock);
    $display("FAIL watchdog: got cycle %0d expected finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // receive-side scoreboard and pulse counters
  always @(negedge clock) begin
    if (rx_byte_valid) begin
      rx_valid_cnt++;
      last_valid_cyc = cyc;
      check("rx_q_nonempty", 32'(rx_exp_q.size() != 0), 1);
      if (rx_exp_q.size() != 0) check("rx_byte", 32'(rx_byte), 32'(rx_exp_q.pop_front()));
    end
    if (frame_error) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (state_out) state_hi_seen = 1'b1;
  end

  // tx_line decoder; a reset during a frame abandons it
  logic [7:0] mon_b;
  logic       mon_stop;
  bit         mon_ab;
  int         mon_cpd;

  task automatic mon_wait(input int n, inout bit ab);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (reset) ab = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && tx_line === 1'b0) begin
        mon_ab = 1'b0;
        mon_cpd = cpd;
        frame_starts.push_back(cyc);
        mon_wait(mon_cpd / 2, mon_ab);
        for (int i = 0; i < 8; i++) begin
          mon_wait(mon_cpd, mon_ab);
          mon_b[i] = tx_line;
        end
        mon_wait(mon_cpd, mon_ab);
        mon_stop = tx_line;
        if (!mon_ab) begin
          check("tx_q_nonempty", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("tx_byte", 32'(mon_b), 32'(exp_q.pop_front()));
          check("tx_stop_bit", 32'(mon_stop), 1);
        end
      end
    end
  end

  // driver tasks
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    rx_line = 1'b0;
    repeat (cpd) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (cpd) @(negedge clock);
    end
    rx_line = stop_v;
    repeat (cpd) @(negedge clock);
    rx_line = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    rx_exp_q.push_back(b);
    send_frame(b, 1'b1);
  endtask

  task automatic send_at(input logic [7:0] a, input logic [7:0] b);
    send_good(a);
    send_good(b);
    send_good(8'h0D);
    send_good(8'h0A);
  endtask

  task automatic push_ok();
    exp_q.push_back(8'h4F); exp_q.push_back(8'h4B);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  task automatic push_err();
    exp_q.push_back(8'h45); exp_q.push_back(8'h52); exp_q.push_back(8'h52);
    exp_q.push_back(8'h4F); exp_q.push_back(8'h52);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || rx_exp_q.size() != 0) && n < limit) begin
      @(negedge clock);
      n++;
    end
    check(tag, exp_q.size() + rx_exp_q.size(), 0);
    repeat (2 * cpd) @(negedge clock);
  endtask

  int b0, v0, f0, o0, en_cyc, rise_cyc, n;

  initial begin
    reset = 1'b1; enable_in = 1'b0; at_mode = 1'b1; rx_line = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_tx_line", 32'(tx_line), 1);
    check("rst_state_out", 32'(state_out), 0);
    check("rst_rx_byte", 32'(rx_byte), 0);
    check("rst_pulses", 32'({rx_byte_valid, frame_error, overrun}), 0);
    check("rst_tx_busy", 32'(tx_busy), 0);
    reset = 1'b0;
    enable_in = 1'b1;
    repeat (5) @(negedge clock);

    // AT: "AT" -> OK, no gaps, first start one cycle after LF valid
    b0 = frame_starts.size();
    push_ok();
    send_at(8'h41, 8'h54);
    wait_drain("ok1_drain", 3000);
    check("ok1_frames", frame_starts.size() - b0, 4);
    check("ok1_latency", frame_starts[b0], last_valid_cyc + 1);
    check("ok1_span", frame_starts[b0+3] - frame_starts[b0], 30 * cpd);

    // AT: "XY" -> ERROR
    b0 = frame_starts.size();
    push_err();
    send_at(8'h58, 8'h59);
    wait_drain("err1_drain", 4000);
    check("err1_frames", frame_starts.size() - b0, 7);
    check("err1_span", frame_starts[b0+6] - frame_starts[b0], 60 * cpd);

    // AT: 20 x 'A' overflows the line buffer -> ERROR, then a clean OK
    push_err();
    for (int i = 0; i < 20; i++) send_good(8'h41);
    send_good(8'h0D);
    send_good(8'h0A);
    wait_drain("ovf_drain", 4000);
    push_ok();
    send_at(8'h41, 8'h54);
    wait_drain("ok2_drain", 3000);

    // frame with low stop bit
    v0 = rx_valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    repeat (cpd) @(negedge clock);
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_no_valid", rx_valid_cnt - v0, 0);
    check("ferr_rx_byte", 32'(rx_byte), 32'h0A);
    check("at_state_out_low", 32'(state_hi_seen), 0);

    // reset during the third response byte, then a fresh OK
    b0 = frame_starts.size();
    exp_q.push_back(8'h4F); exp_q.push_back(8'h4B);
    send_at(8'h41, 8'h54);
    n = 0;
    while (frame_starts.size() < b0 + 3 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("rst_third_frame", 32'(frame_starts.size() >= b0 + 3), 1);
    repeat (3 * cpd) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_tx_line", 32'(tx_line), 1);
    check("midrst_tx_busy", 32'(tx_busy), 0);
    @(negedge clock);
    check("midrst_state_out", 32'(state_out), 0);
    check("midrst_pulses", 32'({rx_byte_valid, frame_error, overrun}), 0);
    check("midrst_two_frames_done", exp_q.size(), 0);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    push_ok();
    send_at(8'h41, 8'h54);
    wait_drain("ok3_drain", 3000);

    // data mode: connect delay
    enable_in = 1'b0;
    at_mode = 1'b0;
    repeat (5) @(negedge clock);
    check("dis_state_out", 32'(state_out), 0);
    en_cyc = cyc;
    enable_in = 1'b1;
    rise_cyc = -1;
    for (int k = 0; k < 500 && rise_cyc < 0; k++) begin
      @(negedge clock);
      if (state_out) rise_cyc = cyc;
    end
    check("connect_delay", rise_cyc - (en_cyc + 1), 32'(CD));

    // echo latency
    b0 = frame_starts.size();
    exp_q.push_back(8'h55);
    send_good(8'h55);
    wait_drain("echo_drain", 2000);
    check("echo_latency", frame_starts[b0], last_valid_cyc + 1);

    // 11 then fast 22, 33 while echo of 11 is still busy: 33 dropped
    b0 = frame_starts.size();
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_good(8'h11);
    cpd = 8;
    send_good(8'h22);
    send_good(8'h33);
    cpd = 26;
    wait_drain("ovr_drain", 3000);
    repeat (10 * cpd) @(negedge clock);
    check("ovr_pulses", ovr_cnt - o0, 1);
    check("ovr_frames", frame_starts.size() - b0, 2);

    // disable drops state_out next cycle
    check("conn_state_out", 32'(state_out), 1);
    enable_in = 1'b0;
    @(negedge clock);
    check("disable_state_out", 32'(state_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
